// File: rtl/cfi_pkg.sv
// Shared types, cause codes and instruction classification for the commit-stage CFI monitor.
package cfi_pkg;

  localparam int NR_COMMIT_PORTS = 2;

  typedef enum logic [3:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;
  typedef enum logic [7:0] {ADD, SUB, ANDL, ORL, JAL, JALR, EQ, NE} fu_op;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        use_imm;
    logic        is_compressed;
  } scoreboard_entry_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] RET_MISMATCH = 64'd24;
  localparam logic [63:0] MARK_MISSING = 64'd25;
  localparam logic [63:0] OVERFLOW     = 64'd26;
  localparam logic [63:0] UNDERFLOW    = 64'd27;

  localparam logic [63:0] RET_SITE  = 64'd1;
  localparam logic [63:0] CALL_SITE = 64'd2;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  typedef struct packed {
    logic is_call;
    logic is_ret;
    logic is_ret_mark;
  } cfi_class_t;

  function automatic logic is_link(logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

  function automatic logic [63:0] link_addr(scoreboard_entry_t e);
    return e.pc + (e.is_compressed ? 64'd2 : 64'd4);
  endfunction

  // A JALR whose rd and rs1 are both link registers classifies as ret and call at once.
  function automatic cfi_class_t classify(scoreboard_entry_t e);
    cfi_class_t c;
    logic       cf;
    cf            = (e.fu == CTRL_FLOW);
    c.is_call     = cf && ((e.op == JAL) || (e.op == JALR)) && is_link(e.rd);
    c.is_ret      = cf && (e.op == JALR) && is_link(e.rs1) && ((e.rd == 5'd0) || is_link(e.rd));
    c.is_ret_mark = (e.fu == ALU) && (e.op == ADD) && (e.rd == 5'd0) && (e.rs1 == 5'd0)
                    && e.use_imm && (e.result == RET_SITE);
    return c;
  endfunction

endpackage

// File: rtl/cfi_lifo.sv
// Shadow return-address stack: per port a pop then a push, chained in port order within one cycle.
module cfi_lifo #(
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 16,
  parameter bit OVF_WRAP = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NR_PORTS-1:0]          push_req,
  input  logic [63:0]                  push_data [NR_PORTS],
  input  logic [NR_PORTS-1:0]          pop_req,
  output logic [63:0]                  pop_data [NR_PORTS],
  output logic [NR_PORTS-1:0]          underflow,
  output logic [NR_PORTS-1:0]          overflow,
  output logic [NR_PORTS-1:0]          wrapped,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // ptr points at the next free slot; with wrap enabled and the stack full it
  // also points at the oldest entry, so a push there overwrites it.
  always_comb begin
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    mem_d     = mem_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    underflow = '0;
    overflow  = '0;
    wrapped   = '0;
    for (int n = 0; n < NR_PORTS; n++) begin
      pop_data[n] = '0;
      if (pop_req[n]) begin
        if (cnt_d == '0) begin
          underflow[n] = 1'b1;
        end else begin
          ptr_d       = ptr_d - PW'(1);
          pop_data[n] = mem_d[ptr_d];
          cnt_d       = cnt_d - CW'(1);
        end
      end
      if (push_req[n]) begin
        if ((cnt_d == FULL) && !OVF_WRAP) begin
          overflow[n] = 1'b1;
        end else begin
          mem_d[ptr_d] = push_data[n];
          ptr_d        = ptr_d + PW'(1);
          if (cnt_d == FULL) wrapped[n] = 1'b1;
          else               cnt_d = cnt_d + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage has no reset; cnt_q guards every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/cfi_shadow_stack_commit_monitor.sv
// Commit-stage CFI monitor: shadow-stack calls/returns and check each return landing site.
module cfi_shadow_stack_commit_monitor
  import cfi_pkg::*;
#(
  parameter int NR_PORTS     = NR_COMMIT_PORTS,
  parameter int DEPTH        = 16,
  parameter bit OVF_WRAP     = 1'b0,
  parameter bit REQUIRE_MARK = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        csr_en_i,
  input  scoreboard_entry_t           commit_instr_i [NR_PORTS],
  input  logic [NR_PORTS-1:0]         commit_ack_i,
  output exception_t                  exception_o,
  output logic                        alarm_o,
  output logic [$clog2(DEPTH+1)-1:0]  depth_o,
  output logic [3:0]                  leds_o
);

  cfi_class_t          cls [NR_PORTS];
  logic [NR_PORTS-1:0] act, push_req, pop_req, underflow, overflow, wrapped;
  logic [63:0]         push_data [NR_PORTS];
  logic [63:0]         pop_data  [NR_PORTS];

  logic        pending_q, pending_d;
  logic [63:0] chk_q, chk_d;
  logic        viol;
  logic [63:0] viol_cause, viol_tval;
  exception_t  exc_q;
  logic        alarm_q, ovf_seen_q;

  always_comb begin
    act      = '0;
    push_req = '0;
    pop_req  = '0;
    for (int n = 0; n < NR_PORTS; n++) begin
      cls[n]       = classify(commit_instr_i[n]);
      act[n]       = commit_ack_i[n] && csr_en_i;
      push_req[n]  = act[n] && cls[n].is_call;
      pop_req[n]   = act[n] && cls[n].is_ret;
      push_data[n] = link_addr(commit_instr_i[n]);
    end
  end

  cfi_lifo #(
    .NR_PORTS (NR_PORTS),
    .DEPTH    (DEPTH),
    .OVF_WRAP (OVF_WRAP)
  ) u_lifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push_req  (push_req),
    .push_data (push_data),
    .pop_req   (pop_req),
    .pop_data  (pop_data),
    .underflow (underflow),
    .overflow  (overflow),
    .wrapped   (wrapped),
    .count     (depth_o)
  );

  // Walk the ports in program order; a port first answers any outstanding return
  // check, then performs its own pop and push. Only the first violation is kept.
  always_comb begin
    logic [63:0] c;
    c          = '0;
    // NOTE: blocking assignments here let each port see the pending/chk values left by earlier ports.
    pending_d  = pending_q;
    chk_d      = chk_q;
    viol       = 1'b0;
    viol_cause = '0;
    viol_tval  = '0;
    for (int n = 0; n < NR_PORTS; n++) begin
      c = '0;
      if (act[n]) begin
        if (pending_d) begin
          if (commit_instr_i[n].pc != chk_d)            c = RET_MISMATCH;
          else if (REQUIRE_MARK && !cls[n].is_ret_mark) c = MARK_MISSING;
          pending_d = 1'b0;
        end
        if (pop_req[n]) begin
          if (underflow[n]) begin
            if (c == '0) c = UNDERFLOW;
          end else begin
            pending_d = 1'b1;
            chk_d     = pop_data[n];
          end
        end
        if (overflow[n] && (c == '0)) c = OVERFLOW;
      end
      if ((c != '0) && !viol) begin
        viol       = 1'b1;
        viol_cause = c;
        viol_tval  = commit_instr_i[n].pc;
      end
    end
    if (!csr_en_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      chk_q      <= '0;
      exc_q      <= '0;
      alarm_q    <= 1'b0;
      ovf_seen_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      chk_q     <= chk_d;
      if (viol)     alarm_q    <= 1'b1;
      if (|wrapped) ovf_seen_q <= 1'b1;
      if (flush_i || !viol) exc_q <= '0;
      else                  exc_q <= '{cause: viol_cause, tval: viol_tval, valid: 1'b1};
    end
  end

  assign exception_o = exc_q;
  assign alarm_o     = alarm_q;
  assign leds_o      = {alarm_q, ovf_seen_q, (depth_o != '0), csr_en_i};

endmodule

// File: tb/tb_cfi_shadow_stack_commit_monitor.sv
// Directed bench: a drop-mode and a wrap-mode monitor (DEPTH=4) share one commit stream.
module tb_cfi_shadow_stack_commit_monitor;
  import cfi_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni, flush, en;
  scoreboard_entry_t instr [2];
  logic [1:0]        ack;
  exception_t        exc_d, exc_w;
  logic              alarm_d, alarm_w;
  logic [2:0]        dep_d, dep_w;
  logic [3:0]        leds_d, leds_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cfi_shadow_stack_commit_monitor #(.NR_PORTS(2), .DEPTH(4), .OVF_WRAP(1'b0), .REQUIRE_MARK(1'b1)) dut_d (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .csr_en_i(en), .commit_instr_i(instr),
    .commit_ack_i(ack), .exception_o(exc_d), .alarm_o(alarm_d), .depth_o(dep_d), .leds_o(leds_d));

  cfi_shadow_stack_commit_monitor #(.NR_PORTS(2), .DEPTH(4), .OVF_WRAP(1'b1), .REQUIRE_MARK(1'b1)) dut_w (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .csr_en_i(en), .commit_instr_i(instr),
    .commit_ack_i(ack), .exception_o(exc_w), .alarm_o(alarm_w), .depth_o(dep_w), .leds_o(leds_w));

  typedef struct {
    scoreboard_entry_t i0, i1;
    logic              a0, a1, fl;
    logic              ev;
    logic [63:0]       ec, et;
    logic [2:0]        ed;
    logic              ea;
  } vec_t;

  vec_t vt [$];

  function automatic scoreboard_entry_t e_idle();
    scoreboard_entry_t e;
    e = '0; e.fu = NONE; e.op = ADD;
    return e;
  endfunction

  function automatic scoreboard_entry_t e_call(logic [63:0] pc, logic comp);
    scoreboard_entry_t e;
    e = e_idle(); e.pc = pc; e.fu = CTRL_FLOW; e.op = JAL; e.rd = 5'd1; e.is_compressed = comp;
    return e;
  endfunction

  function automatic scoreboard_entry_t e_jalr(logic [63:0] pc, logic [4:0] rd, logic [4:0] rs1);
    scoreboard_entry_t e;
    e = e_idle(); e.pc = pc; e.fu = CTRL_FLOW; e.op = JALR; e.rd = rd; e.rs1 = rs1;
    return e;
  endfunction

  function automatic scoreboard_entry_t e_ret(logic [63:0] pc);
    return e_jalr(pc, 5'd0, 5'd1);
  endfunction

  function automatic scoreboard_entry_t e_mark(logic [63:0] pc, logic [63:0] code);
    scoreboard_entry_t e;
    e = e_idle(); e.pc = pc; e.fu = ALU; e.op = ADD; e.use_imm = 1'b1; e.result = code;
    return e;
  endfunction

  function automatic scoreboard_entry_t e_add(logic [63:0] pc);
    scoreboard_entry_t e;
    e = e_idle(); e.pc = pc; e.fu = ALU; e.op = ADD; e.rd = 5'd10; e.rs1 = 5'd10;
    e.use_imm = 1'b1; e.result = 64'd7;
    return e;
  endfunction

  function automatic vec_t mk(scoreboard_entry_t i0, logic a0, scoreboard_entry_t i1, logic a1,
                              logic fl, logic ev, logic [63:0] ec, logic [63:0] et,
                              logic [2:0] ed, logic ea);
    vec_t v;
    v.i0 = i0; v.a0 = a0; v.i1 = i1; v.a1 = a1; v.fl = fl;
    v.ev = ev; v.ec = ec; v.et = et; v.ed = ed; v.ea = ea;
    return v;
  endfunction

  function automatic vec_t s1(scoreboard_entry_t i0, logic ev, logic [63:0] ec, logic [63:0] et,
                              logic [2:0] ed, logic ea);
    return mk(i0, 1'b1, e_idle(), 1'b0, 1'b0, ev, ec, et, ed, ea);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exception_t e, input logic [2:0] d, input logic a,
                         input logic ev, input logic [63:0] ec, input logic [63:0] et,
                         input logic [2:0] ed, input logic ea);
    check({tag, " valid"}, 64'(e.valid), 64'(ev));
    check({tag, " cause"}, e.cause, ec);
    check({tag, " tval"},  e.tval,  et);
    check({tag, " depth"}, 64'(d),  64'(ed));
    check({tag, " alarm"}, 64'(a),  64'(ea));
  endtask

  task automatic drive(input scoreboard_entry_t i0, input logic a0, input scoreboard_entry_t i1,
                       input logic a1, input logic e, input logic fl);
    instr[0] = i0; ack[0] = a0; instr[1] = i1; ack[1] = a1; en = e; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit1(input scoreboard_entry_t i0, input logic e);
    drive(i0, 1'b1, e_idle(), 1'b0, e, 1'b0);
    step();
  endtask

  task automatic do_reset();
    drive(e_idle(), 1'b0, e_idle(), 1'b0, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #7;
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(e_idle(), 1'b0, e_idle(), 1'b0, 1'b1, 1'b0);
    #3;
    chk_out("reset d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0);
    check("reset leds d", 64'(leds_d), 64'h1);
    #9;
    rst_ni = 1'b1;
    step();

    vt.push_back(mk(e_idle(), 1'b0, e_idle(), 1'b0, 1'b0, 0, 0, 0, 3'd0, 0));
    vt.push_back(s1(e_call(64'h100, 1'b0), 0, 0, 0, 3'd1, 0));
    vt.push_back(s1(e_ret(64'h800),        0, 0, 0, 3'd0, 0));
    vt.push_back(s1(e_mark(64'h104, RET_SITE), 0, 0, 0, 3'd0, 0));
    vt.push_back(s1(e_call(64'h200, 1'b0), 0, 0, 0, 3'd1, 0));
    vt.push_back(s1(e_ret(64'h900),        0, 0, 0, 3'd0, 0));
    vt.push_back(s1(e_add(64'h300),        1, 64'd24, 64'h300, 3'd0, 1));
    vt.push_back(mk(e_idle(), 1'b0, e_idle(), 1'b0, 1'b0, 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_ret(64'hA00),        1, 64'd27, 64'hA00, 3'd0, 1));
    vt.push_back(s1(e_add(64'hB00),        0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_call(64'h500, 1'b0), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_ret(64'h900),        0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_add(64'h504),        1, 64'd25, 64'h504, 3'd0, 1));
    vt.push_back(mk(e_call(64'h400, 1'b0), 1'b1, e_ret(64'h1000), 1'b1, 1'b0, 0, 0, 0, 3'd0, 1));
    vt.push_back(mk(e_idle(), 1'b0, e_idle(), 1'b0, 1'b0, 0, 0, 0, 3'd0, 1));
    vt.push_back(mk(e_mark(64'h404, RET_SITE), 1'b1, e_idle(), 1'b0, 1'b0, 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_call(64'h600, 1'b1), 0, 0, 0, 3'd1, 1));
    vt.push_back(mk(e_ret(64'h1100), 1'b1, e_mark(64'h602, RET_SITE), 1'b1, 1'b0, 0, 0, 0, 3'd0, 1));
    vt.push_back(mk(e_ret(64'h1200), 1'b1, e_ret(64'h1300), 1'b1, 1'b0, 1, 64'd27, 64'h1200, 3'd0, 1));
    vt.push_back(s1(e_call(64'h700, 1'b0), 0, 0, 0, 3'd1, 1));
    vt.push_back(mk(e_ret(64'h1400), 1'b1, e_mark(64'h999, RET_SITE), 1'b1, 1'b0, 1, 64'd24, 64'h999, 3'd0, 1));
    vt.push_back(s1(e_call(64'h800, 1'b0), 0, 0, 0, 3'd1, 1));
    vt.push_back(mk(e_idle(), 1'b0, e_idle(), 1'b0, 1'b1, 0, 0, 0, 3'd1, 1));
    vt.push_back(mk(e_ret(64'h1600), 1'b1, e_idle(), 1'b0, 1'b1, 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_mark(64'h804, RET_SITE), 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_call(64'h900, 1'b0), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_jalr(64'h1700, 5'd1, 5'd5), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_mark(64'h904, RET_SITE), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_ret(64'h1800),       0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_mark(64'h1704, RET_SITE), 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_call(64'hA00, 1'b0), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_ret(64'h1900),       0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_mark(64'hA04, CALL_SITE), 1, 64'd25, 64'hA04, 3'd0, 1));
    vt.push_back(s1(e_jalr(64'hC00, 5'd5, 5'd6), 0, 0, 0, 3'd1, 1));
    vt.push_back(s1(e_jalr(64'h1A00, 5'd0, 5'd5), 0, 0, 0, 3'd0, 1));
    vt.push_back(s1(e_mark(64'hC04, RET_SITE), 0, 0, 0, 3'd0, 1));
    vt.push_back(mk(e_idle(), 1'b0, e_idle(), 1'b0, 1'b0, 0, 0, 0, 3'd0, 1));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].i0, vt[i].a0, vt[i].i1, vt[i].a1, 1'b1, vt[i].fl);
      step();
      chk_out($sformatf("vec%0d d", i), exc_d, dep_d, alarm_d,
              vt[i].ev, vt[i].ec, vt[i].et, vt[i].ed, vt[i].ea);
      chk_out($sformatf("vec%0d w", i), exc_w, dep_w, alarm_w,
              vt[i].ev, vt[i].ec, vt[i].et, vt[i].ed, vt[i].ea);
    end

    // Overflow: drop mode reports cause 26, wrap mode silently overwrites the oldest link.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      commit1(e_call(64'(k * 16), 1'b0), 1'b1);
      check($sformatf("ovf call%0d depth d", k), 64'(dep_d), 64'(k));
      check($sformatf("ovf call%0d depth w", k), 64'(dep_w), 64'(k));
    end
    commit1(e_call(64'h50, 1'b0), 1'b1);
    chk_out("ovf 5th d", exc_d, dep_d, alarm_d, 1'b1, 64'd26, 64'h50, 3'd4, 1'b1);
    chk_out("ovf 5th w", exc_w, dep_w, alarm_w, 1'b0, 64'd0, 64'd0, 3'd4, 1'b0);
    check("ovf_seen led d", 64'(leds_d[2]), 64'd0);
    check("ovf_seen led w", 64'(leds_w[2]), 64'd1);
    for (int j = 0; j < 4; j++) begin
      commit1(e_ret(64'h2000 + 64'(j * 256)), 1'b1);
      chk_out($sformatf("wrap ret%0d w", j), exc_w, dep_w, alarm_w, 1'b0, 64'd0, 64'd0, 3'(3 - j), 1'b0);
      commit1(e_mark(64'h54 - 64'(j * 16), RET_SITE), 1'b1);
      chk_out($sformatf("wrap mark%0d w", j), exc_w, dep_w, alarm_w, 1'b0, 64'd0, 64'd0, 3'(3 - j), 1'b0);
    end
    commit1(e_ret(64'h3000), 1'b1);
    chk_out("wrap ret5 w", exc_w, dep_w, alarm_w, 1'b1, 64'd27, 64'h3000, 3'd0, 1'b1);

    // Reset lands with depth 3, a pending check and a live exception.
    do_reset();
    for (int k = 1; k <= 4; k++) commit1(e_call(64'(k * 256), 1'b0), 1'b1);
    drive(e_call(64'h500, 1'b0), 1'b1, e_ret(64'h4000), 1'b1, 1'b1, 1'b0);
    step();
    chk_out("prerst d", exc_d, dep_d, alarm_d, 1'b1, 64'd26, 64'h500, 3'd3, 1'b1);
    check("prerst leds w", 64'(leds_w), 64'h7);
    drive(e_idle(), 1'b0, e_idle(), 1'b0, 1'b1, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    chk_out("inrst d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0);
    check("inrst leds d", 64'(leds_d), 64'h1);
    check("inrst leds w", 64'(leds_w), 64'h1);
    #3;
    rst_ni = 1'b1;
    step();
    commit1(e_ret(64'h5000), 1'b1);
    chk_out("postrst ret d", exc_d, dep_d, alarm_d, 1'b1, 64'd27, 64'h5000, 3'd0, 1'b1);

    // Monitor disabled: stack held, no checks, pending dropped.
    do_reset();
    commit1(e_call(64'h100, 1'b0), 1'b1);
    commit1(e_ret(64'h3000), 1'b0);
    chk_out("dis ret d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd1, 1'b0);
    check("dis leds d", 64'(leds_d), 64'h2);
    commit1(e_add(64'h4000), 1'b0);
    chk_out("dis add d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd1, 1'b0);
    commit1(e_add(64'h5000), 1'b1);
    chk_out("reen add d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd1, 1'b0);
    commit1(e_ret(64'h3100), 1'b1);
    check("en ret depth d", 64'(dep_d), 64'd0);
    drive(e_idle(), 1'b0, e_idle(), 1'b0, 1'b0, 1'b0);
    step();
    commit1(e_add(64'h6000), 1'b1);
    chk_out("pend drop d", exc_d, dep_d, alarm_d, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
